// File: rtl/sqrt_share_ctrl.sv
// rtl/sqrt_share_ctrl.sv - round-robin time-sharing controller for one square-root unit
module sqrt_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 40,
  parameter int PTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 sqrt_en,
  output logic [31:0]          sqrt_d,
  input  logic [15:0]          sqrt_result,
  input  logic                 sqrt_done
);

  // Watchdog needs to reach TIMEOUT-1; one extra bit keeps saturation headroom.
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gid;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    scan_idx;
  logic [WD_W-1:0]     wd;
  logic                wd_expired;
  logic [N_REQ-1:0]    gid_onehot;
  logic [N_REQ-1:0]    grant_onehot;
  logic [PTR_W-1:0]    ptr_after_grant;

  assign wd_expired      = (wd >= WD_LAST);
  assign gid_onehot      = N_REQ'(1) << gid;
  assign grant_onehot    = N_REQ'(1) << grant_idx;
  assign ptr_after_grant = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: a run ends on the first done, or when the watchdog runs out.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_any) state_nx = S_RUN;
      S_RUN:   if (sqrt_done || wd_expired) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Combinational outputs: accept strobe only while idle, busy outside idle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    case (state)
      S_IDLE:  if (grant_any) req_ready = grant_onehot;
      S_RUN:   busy = 1'b1;
      S_DRAIN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: grant capture, watchdog, response registers and unit enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sqrt_en     <= 1'b0;
      sqrt_d      <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      gid         <= '0;
      wd          <= '0;
    end else begin
      // Enable follows the RUN state one-for-one; DRAIN gives the one low cycle.
      sqrt_en     <= (state_nx == S_RUN);
      rsp_valid   <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            sqrt_d <= req_data[32*grant_idx +: 32];
            gid    <= grant_idx;
            rr_ptr <= ptr_after_grant;
            wd     <= '0;
          end
        end
        S_RUN: begin
          if (wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
          // A real result beats a watchdog expiry landing in the same cycle.
          if (sqrt_done) begin
            rsp_data  <= sqrt_result;
            rsp_valid <= gid_onehot;
          end else if (wd_expired) begin
            rsp_data    <= '0;
            rsp_valid   <= gid_onehot;
            timeout_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// tb/tb_sqrt_share_ctrl.sv - self-checking bench for sqrt_share_ctrl
module tb_sqrt_share_ctrl;

  localparam int N  = 4;
  localparam int TO = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_data;
  logic            timeout_err;
  logic            busy;
  logic            sqrt_en;
  logic [31:0]     sqrt_d;
  logic [15:0]     sqrt_result;
  logic            sqrt_done = 1'b0;

  always #5 clk = ~clk;

  sqrt_share_ctrl #(.N_REQ(N), .TIMEOUT(TO), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .timeout_err(timeout_err),
    .busy(busy), .sqrt_en(sqrt_en), .sqrt_d(sqrt_d),
    .sqrt_result(sqrt_result), .sqrt_done(sqrt_done)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(v)) r = t;
    end
    return 16'(r);
  endfunction

  // Square-root unit model: done rises after u_lat enabled cycles and lingers one cycle after enable drops.
  int u_lat = 32;
  bit withhold = 1'b0;
  int u_cnt = 0;
  always @(posedge clk) begin
    if (!sqrt_en) begin
      u_cnt     <= 0;
      sqrt_done <= 1'b0;
    end else begin
      if (u_cnt < u_lat) u_cnt <= u_cnt + 1;
      if (!withhold && (u_cnt + 1 >= u_lat)) sqrt_done <= 1'b1;
    end
  end
  assign sqrt_result = sqrt_done ? isqrt(sqrt_d) : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one job at a time, timestamped accept/response.
  logic [31:0] q[N][$];
  int          cyc = 0;
  bit          job_active = 1'b0;
  int          acc_cyc = 0;
  int          resp_cyc = 0;
  int          job_g = 0;
  logic [31:0] job_data = '0;
  logic [15:0] job_val = '0;
  bit          job_to = 1'b0;
  int          ptr = 0;
  bit          rst_next = 1'b0;
  int          obs_order[$];
  int          last_acc_cyc = 0;
  int          last_rsp_cyc = 0;
  logic [15:0] last_rsp_data = '0;

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    bit           acc;
    int           g;
    int           idx;
    bit           exp_run;
    @(posedge clk);
    #2;
    cyc++;
    rst = rst_next;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        v[i] = 1'b1;
        req_data[32*i +: 32] = q[i][0];
      end
    end
    req_valid = v;
    #2;
    acc = !job_active && !rst && (v != '0);
    g = -1;
    exp_ready = '0;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
      exp_ready[g] = 1'b1;
    end
    exp_run = job_active && (cyc < resp_cyc);
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, job_active);
    chk("sqrt_en", sqrt_en, exp_run);
    if (exp_run) chk("sqrt_d", sqrt_d, job_data);
    if (job_active && cyc == resp_cyc) begin
      chk("rsp_valid", rsp_valid, N'(1) << job_g);
      chk("rsp_data", rsp_data, job_val);
      chk("timeout_err", timeout_err, job_to);
    end else begin
      chk("rsp_valid_idle", rsp_valid, '0);
      chk("timeout_err_idle", timeout_err, 1'b0);
    end
    if (req_ready != '0) last_acc_cyc = cyc;
    if (rsp_valid != '0) begin
      last_rsp_cyc  = cyc;
      last_rsp_data = rsp_data;
      for (int k = 0; k < N; k++) if (rsp_valid[k]) obs_order.push_back(k);
    end
    if (job_active && cyc == resp_cyc) job_active = 1'b0;
    if (acc) begin
      job_active = 1'b1;
      acc_cyc    = cyc;
      job_g      = g;
      job_data   = q[g].pop_front();
      job_to     = withhold || (u_lat + 1 > TO);
      resp_cyc   = cyc + (job_to ? TO : u_lat + 1) + 1;
      job_val    = job_to ? 16'h0 : isqrt(job_data);
      ptr        = (g + 1) % N;
    end
    if (rst) begin
      job_active = 1'b0;
      ptr        = 0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((job_active || !queues_empty()) && k < 3000) begin
      step();
      k++;
    end
    chk("drain_bound", {job_active, queues_empty()}, 2'b01);
  endtask

  task automatic chk_order(input string tag, input int n, input int a0, input int a1, input int a2, input int a3);
    int exp_o[4];
    exp_o = '{a0, a1, a2, a3};
    chk({tag, "_len"}, obs_order.size(), n);
    for (int i = 0; i < n && i < obs_order.size(); i++) chk(tag, obs_order[i], exp_o[i]);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    #4;
    chk("rst_sqrt_en", sqrt_en, 1'b0);
    chk("rst_sqrt_d", sqrt_d, 32'h0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, '0);

    // Single request, 32-cycle unit: response 34 cycles after accept.
    q[1].push_back(32'h0000_0010);
    drain();
    chk("A_latency", last_rsp_cyc - last_acc_cyc, 34);
    chk("A_data", last_rsp_data, 16'h0004);

    // Back-to-back requests from requester 0, extreme radicands.
    q[0].push_back(32'hFFFF_FFFF);
    q[0].push_back(32'h0000_0000);
    drain();
    chk("B_last_data", last_rsp_data, 16'h0000);

    // Fresh reset, then all four requesters at once.
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    obs_order.delete();
    q[0].push_back(32'd4);
    q[1].push_back(32'd9);
    q[2].push_back(32'd16);
    q[3].push_back(32'd25);
    drain();
    chk_order("C_order", 4, 0, 1, 2, 3);

    // Requesters 0 and 2 held valid continuously.
    u_lat = $urandom_range(1, 10);
    obs_order.delete();
    for (int i = 0; i < 2; i++) begin
      q[0].push_back($urandom);
      q[2].push_back($urandom);
    end
    drain();
    chk_order("D_order", 4, 0, 2, 0, 2);

    // Unit never finishes: watchdog response, then normal service resumes.
    withhold = 1'b1;
    q[3].push_back($urandom);
    drain();
    chk("E_to_latency", last_rsp_cyc - last_acc_cyc, TO + 1);
    withhold = 1'b0;
    u_lat = $urandom_range(1, 30);
    q[3].push_back($urandom);
    drain();

    // Done and watchdog expiry in the same cycle, then one cycle too late.
    u_lat = TO - 1;
    q[2].push_back($urandom);
    drain();
    u_lat = TO;
    q[1].push_back($urandom);
    drain();

    // Reset on the 10th RUN cycle aborts the job and rewinds the pointer.
    u_lat = 32;
    q[2].push_back($urandom);
    k = 0;
    while (!(job_active && cyc == acc_cyc + 9) && k < 200) begin
      step();
      k++;
    end
    chk("G_reach_run10", job_active && cyc == acc_cyc + 9, 1'b1);
    obs_order.delete();
    q[1].push_back(32'd49);
    q[3].push_back(32'd64);
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    step();
    drain();
    chk_order("G_order", 2, 1, 3, 0, 0);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      u_lat = $urandom_range(1, 45);
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) q[$urandom_range(0, N-1)].push_back($urandom);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
